// File: rtl/rv_cache_sint_top.sv
// Self-integrated cache test top: LFSR traffic generator, direct-mapped write-back cache,
// fixed-latency word memory and a shadow-memory checker.
module rv_cache_sint_top #(
    parameter int          DATA_W      = 32,
    parameter int          LINE_WORDS  = 4,
    parameter int          NUM_LINES   = 16,
    parameter int          MEM_WORDS   = 1024,
    parameter int          MEM_LATENCY = 4,
    parameter int          NUM_OPS     = 256,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          INJECT_ERR  = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int IW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CW    = NUM_LINES * LINE_WORDS;
    localparam int SW    = (CW > 1) ? $clog2(CW) : 1;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int OPW   = $clog2(NUM_OPS + 1);
    localparam logic [AW-1:0]     LW_A      = AW'(LINE_WORDS);
    localparam logic [AW-1:0]     NL_A      = AW'(NUM_LINES);
    localparam logic [AW-1:0]     CW_A      = AW'(CW);
    localparam logic [AW-1:0]     LW_LAST   = AW'(LINE_WORDS - 1);
    localparam logic [AW-1:0]     INIT_LAST = AW'(MEM_WORDS - 1);
    localparam logic [OPW-1:0]    OP_LAST   = OPW'(NUM_OPS - 1);
    localparam logic [DATA_W-1:0] INJ_MASK  = (INJECT_ERR != 0) ? DATA_W'(1) : '0;

    typedef enum logic [1:0] {G_INIT, G_ISSUE, G_WAIT, G_DONE} gen_state_t;
    typedef enum logic [2:0] {C_IDLE, C_COMPARE, C_RESPOND, C_WRITEBACK, C_ALLOCATE} cache_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    gen_state_t   g_state, g_next;
    cache_state_t c_state, c_next;

    logic [15:0]       lfsr;
    logic [AW-1:0]     init_addr;
    logic [OPW-1:0]    op_count;
    logic              init_we;
    logic              p_we;
    logic [AW-1:0]     p_addr;
    logic [DATA_W-1:0] shadow [MEM_WORDS];

    logic              req_valid, req_ready, req_we, resp_valid;
    logic [AW-1:0]     req_addr;
    logic [DATA_W-1:0] req_wdata, resp_rdata;

    logic              r_we, r_fill;
    logic [AW-1:0]     r_addr, wcnt;
    logic [DATA_W-1:0] r_wdata;
    logic [NUM_LINES-1:0] valid, dirty;
    logic [AW-1:0]     ctag  [NUM_LINES];
    logic [DATA_W-1:0] cdata [CW];

    logic [AW-1:0]     line_no, tag, line_base, victim_base;
    logic [IW-1:0]     idx;
    logic [SW-1:0]     r_slot, fill_slot;
    logic              hit, wc_last;

    logic              mem_req, mem_we, mem_ack, mem_pend;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [LAT_W-1:0]  mem_cnt;
    logic [DATA_W-1:0] mem [MEM_WORDS];

    // ---------------- generator / checker ----------------
    assign req_we    = lfsr[0];
    assign req_addr  = AW'(lfsr[15:1]);
    assign req_wdata = DATA_W'({lfsr, ~lfsr});
    assign pass      = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (!rst) g_state <= G_INIT;
        else      g_state <= g_next;
    end

    always_comb begin
        g_next    = g_state;
        req_valid = 1'b0;
        init_we   = 1'b0;
        case (g_state)
            G_INIT: begin
                init_we = 1'b1;
                if (init_addr == INIT_LAST) g_next = G_ISSUE;
            end
            G_ISSUE: begin
                req_valid = 1'b1;
                if (req_ready) g_next = G_WAIT;
            end
            G_WAIT:  if (resp_valid) g_next = (op_count == OP_LAST) ? G_DONE : G_ISSUE;
            G_DONE:  g_next = G_DONE;
            default: g_next = G_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr      <= SEED;
            init_addr <= '0;
            op_count  <= '0;
            p_we      <= 1'b0;
            p_addr    <= '0;
            err_count <= '0;
            done      <= 1'b0;
        end else begin
            if (init_we) init_addr <= init_addr + AW'(1);
            if (req_valid && req_ready) begin
                p_we   <= req_we;
                p_addr <= req_addr;
                lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
            if (g_state == G_WAIT && resp_valid) begin
                op_count <= op_count + OPW'(1);
                if (!p_we && resp_rdata != shadow[p_addr]) err_count <= sat_inc(err_count);
                if (op_count == OP_LAST) done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (init_we) shadow[init_addr] <= '0;
            else if (req_valid && req_ready && req_we) shadow[req_addr] <= req_wdata;
        end
    end

    // ---------------- cache ----------------
    // Power-of-two geometry: div/mod reduce to bit selects, but stay valid for 1-line/1-word caches.
    assign line_no     = r_addr / LW_A;
    assign idx         = IW'(line_no % NL_A);
    assign tag         = line_no / NL_A;
    assign line_base   = line_no * LW_A;
    assign victim_base = (ctag[idx] * NL_A + AW'(idx)) * LW_A;
    assign r_slot      = SW'(r_addr % CW_A);
    assign fill_slot   = SW'((line_base + wcnt) % CW_A);
    assign hit         = valid[idx] && (ctag[idx] == tag);
    assign wc_last     = (wcnt == LW_LAST);
    assign req_ready   = (c_state == C_IDLE);
    assign resp_rdata  = cdata[r_slot] ^ INJ_MASK;

    always_ff @(posedge clk) begin
        if (!rst) c_state <= C_IDLE;
        else      c_state <= c_next;
    end

    always_comb begin
        c_next     = c_state;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (c_state)
            C_IDLE:    if (req_valid) c_next = C_COMPARE;
            C_COMPARE: begin
                if (hit)                          c_next = C_RESPOND;
                else if (valid[idx] && dirty[idx]) c_next = C_WRITEBACK;
                else                              c_next = C_ALLOCATE;
            end
            C_RESPOND: begin
                resp_valid = 1'b1;
                c_next     = C_IDLE;
            end
            C_WRITEBACK: begin
                mem_req   = !mem_pend;
                mem_we    = 1'b1;
                mem_addr  = victim_base + wcnt;
                mem_wdata = cdata[fill_slot];
                if (mem_ack && wc_last) c_next = C_ALLOCATE;
            end
            C_ALLOCATE: begin
                mem_req  = !mem_pend;
                mem_addr = line_base + wcnt;
                if (mem_ack && wc_last) c_next = C_COMPARE;
            end
            default: c_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= '0;
            dirty      <= '0;
            wcnt       <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_fill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (c_state)
                C_IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_fill  <= 1'b0;
                end
                C_COMPARE: begin
                    // the compare that follows a refill is the same op, so it is not a hit
                    if (hit) begin
                        if (r_we) dirty[idx] <= 1'b1;
                        if (!r_fill) hit_count <= sat_inc(hit_count);
                    end else begin
                        miss_count <= sat_inc(miss_count);
                    end
                end
                C_WRITEBACK, C_ALLOCATE: if (mem_ack) begin
                    wcnt <= wc_last ? '0 : wcnt + AW'(1);
                    if (c_state == C_ALLOCATE && wc_last) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        r_fill     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (c_state == C_COMPARE && hit && r_we) cdata[r_slot] <= r_wdata;
            if (c_state == C_ALLOCATE && mem_ack) begin
                cdata[fill_slot] <= mem_rdata;
                if (wc_last) ctag[idx] <= tag;
            end
        end
    end

    // ---------------- backing memory ----------------
    assign mem_ack = mem_pend && (mem_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_pend <= 1'b0;
            mem_cnt  <= '0;
        end else if (mem_req) begin
            mem_pend <= 1'b1;
            mem_cnt  <= LAT_W'(MEM_LATENCY - 1);
        end else if (mem_ack) begin
            mem_pend <= 1'b0;
        end else if (mem_pend) begin
            mem_cnt  <= mem_cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (init_we) mem[init_addr] <= '0;
            else if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_req) mem_rdata <= mem[mem_addr];
        end
    end

endmodule

// File: tb/tb_rv_cache_sint_top.sv
// Scoreboard bench for rv_cache_sint_top: several parameterised instances, expected
// end-of-run results queued at reset release and checked when each run reports done.
module tb_rv_cache_sint_top;

    localparam int N     = 6;
    localparam int LIMIT = 60000;

    logic        clk, rst_a, rst_b;
    logic        done_v [N];
    logic        pass_v [N];
    logic [15:0] err_v  [N];
    logic [15:0] hit_v  [N];
    logic [15:0] miss_v [N];

    int total = 0, bad = 0, mon_done = 0;
    int cyc_a = 0, cyc_b = 0;

    typedef struct {
        int id; int hits; int misses; int reads; int errs; int cycles; int bound;
    } exp_t;
    exp_t exp_q[$];

    rv_cache_sint_top u_def (.clk(clk), .rst(rst_a), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .hit_count(hit_v[0]), .miss_count(miss_v[0]));
    rv_cache_sint_top #(.LINE_WORDS(1), .NUM_LINES(1)) u_thr (.clk(clk), .rst(rst_a),
        .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]), .hit_count(hit_v[1]),
        .miss_count(miss_v[1]));
    rv_cache_sint_top #(.MEM_LATENCY(1)) u_l1 (.clk(clk), .rst(rst_a), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err_v[2]), .hit_count(hit_v[2]), .miss_count(miss_v[2]));
    rv_cache_sint_top #(.MEM_LATENCY(8)) u_l8 (.clk(clk), .rst(rst_a), .done(done_v[3]),
        .pass(pass_v[3]), .err_count(err_v[3]), .hit_count(hit_v[3]), .miss_count(miss_v[3]));
    rv_cache_sint_top u_rst (.clk(clk), .rst(rst_b), .done(done_v[4]), .pass(pass_v[4]),
        .err_count(err_v[4]), .hit_count(hit_v[4]), .miss_count(miss_v[4]));
    rv_cache_sint_top #(.INJECT_ERR(1)) u_inj (.clk(clk), .rst(rst_a), .done(done_v[5]),
        .pass(pass_v[5]), .err_count(err_v[5]), .hit_count(hit_v[5]), .miss_count(miss_v[5]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst_a) cyc_a = cyc_a + 1; else cyc_a = 0;
        if (rst_b) cyc_b = cyc_b + 1; else cyc_b = 0;
    end

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Reference behaviour: tag-only cache model plus the per-op cycle cost of each path.
    task automatic push_exp(input int id, input int lw, input int nl, input int lat, input bit inj);
        exp_t e;
        logic [15:0] l;
        int tg[16];
        bit vl[16], dt[16];
        int addr, line, slot, t, cyc;
        l = 16'hACE1;
        for (int i = 0; i < 16; i++) begin tg[i] = 0; vl[i] = 0; dt[i] = 0; end
        e.id = id; e.hits = 0; e.misses = 0; e.reads = 0; cyc = 1024;
        for (int op = 0; op < 256; op++) begin
            addr = int'(l[15:1]) % 1024;
            line = addr / lw;
            slot = line % nl;
            t    = line / nl;
            if (vl[slot] && tg[slot] == t) begin
                e.hits++;
                cyc += 3;
            end else begin
                e.misses++;
                cyc += (vl[slot] && dt[slot]) ? 4 + 2 * lw * (lat + 1) : 4 + lw * (lat + 1);
                tg[slot] = t; vl[slot] = 1'b1; dt[slot] = 1'b0;
            end
            if (l[0]) dt[slot] = 1'b1;
            else      e.reads++;
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        e.errs   = inj ? e.reads : 0;
        e.cycles = cyc;
        e.bound  = 1024 + 256 * (3 + 2 * lw * (lat + 1));
        exp_q.push_back(e);
    endtask

    task automatic monitor(input int k);
        bit   seen;
        int   pos, cyc;
        exp_t e;
        seen = 1'b0;
        for (int c = 0; c < LIMIT && !seen; c++) begin
            @(negedge clk);
            if (done_v[k]) seen = 1'b1;
        end
        cyc = (k == 4) ? cyc_b : cyc_a;
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout[%0d]: got done=0 expected done=1 within %0d cycles", k, LIMIT);
        end else begin
            pos = -1;
            for (int j = 0; j < exp_q.size(); j++) if (pos < 0 && exp_q[j].id == k) pos = j;
            if (pos < 0) begin
                total++; bad++;
                $display("FAIL unexpected_done[%0d]: got done=1 expected no run pending", k);
            end else begin
                e = exp_q[pos];
                exp_q.delete(pos);
                chk($sformatf("pass[%0d]", k), pass_v[k], (e.errs == 0) ? 1 : 0);
                chk($sformatf("err_count[%0d]", k), err_v[k], e.errs);
                chk($sformatf("hit_count[%0d]", k), hit_v[k], e.hits);
                chk($sformatf("miss_count[%0d]", k), miss_v[k], e.misses);
                chk($sformatf("ops_total[%0d]", k), hit_v[k] + miss_v[k], 256);
                chk($sformatf("done_cycle[%0d]", k), cyc, e.cycles);
                chk($sformatf("within_bound[%0d]", k), (cyc <= e.bound) ? 1 : 0, 1);
                if (k == 1) chk("thrash_miss_gt_hit", (miss_v[k] > hit_v[k]) ? 1 : 0, 1);
                if (k == 5) chk("inject_err_nonzero", (err_v[k] > 0) ? 1 : 0, 1);
            end
        end
        mon_done++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            fork
                automatic int k = i;
                monitor(k);
            join_none
        end
    end

    initial begin
        int  early;
        bit  hit100;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_done[%0d]", k), done_v[k], 0);
            chk($sformatf("rst_pass[%0d]", k), pass_v[k], 0);
            chk($sformatf("rst_err[%0d]", k), err_v[k], 0);
            chk($sformatf("rst_hit[%0d]", k), hit_v[k], 0);
            chk($sformatf("rst_miss[%0d]", k), miss_v[k], 0);
        end
        push_exp(0, 4, 16, 4, 1'b0);
        push_exp(1, 1, 1, 4, 1'b0);
        push_exp(2, 4, 16, 1, 1'b0);
        push_exp(3, 4, 16, 8, 1'b0);
        push_exp(5, 4, 16, 4, 1'b1);
        rst_a = 1'b1;
        rst_b = 1'b1;

        early = 0;
        repeat (1023) begin
            @(negedge clk);
            if (u_def.req_valid || hit_v[0] != 0 || miss_v[0] != 0) early++;
        end
        chk("no_req_during_init", early, 0);
        @(negedge clk);
        chk("req_after_init", u_def.req_valid, 1);

        hit100 = 1'b0;
        for (int c = 0; c < 30000 && !hit100; c++) begin
            @(negedge clk);
            if (hit_v[4] + miss_v[4] >= 100) hit100 = 1'b1;
        end
        chk("reach_op100", hit100, 1);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_done", done_v[4], 0);
        chk("midrst_hit", hit_v[4], 0);
        chk("midrst_miss", miss_v[4], 0);
        chk("midrst_err", err_v[4], 0);
        push_exp(4, 4, 16, 4, 1'b0);
        rst_b = 1'b1;

        for (int c = 0; c < 70000 && mon_done < N; c++) @(negedge clk);
        if (mon_done < N) begin
            total++; bad++;
            $display("FAIL monitors_finished: got %0d expected %0d", mon_done, N);
        end
        chk("lat1_vs_lat8_hits", hit_v[2], hit_v[3]);
        chk("lat1_vs_lat8_misses", miss_v[2], miss_v[3]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
